// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared constants and helper functions for the PWM output stage.
//   PWM_CNT_W        : width of the free-running PWM counter
//   DUTY_FULL        : duty code that forces a constant-high level
//   PRESCALE_DEFAULT : default system clocks per PWM counter step
//   NUM_PINS         : number of driven output pins
//   PRE_CNT_W        : width of the prescaler counter (PRESCALE up to 65535)
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int             PWM_CNT_W        = 8;
  localparam logic [7:0]     DUTY_FULL        = 8'hFF;
  localparam int             PRESCALE_DEFAULT = 13;
  localparam int             NUM_PINS         = 16;
  localparam int             PRE_CNT_W        = 16;

  // PWM level for one counter step. Full-scale duty also covers the 256th
  // step, which a plain "cnt < duty" compare could never reach.
  function automatic logic pwm_level(
    input logic [PWM_CNT_W-1:0] cnt,
    input logic [PWM_CNT_W-1:0] duty
  );
    logic lvl;
    if (duty == DUTY_FULL) begin
      lvl = 1'b1;
    end else begin
      lvl = (cnt < duty);
    end
    return lvl;
  endfunction

  // Per-pin drive: disabled pins are low, enabled static pins are high,
  // enabled PWM pins follow the shared level.
  function automatic logic [NUM_PINS-1:0] pin_drive(
    input logic [NUM_PINS-1:0] en_out,
    input logic [NUM_PINS-1:0] en_pwm,
    input logic                lvl
  );
    logic [NUM_PINS-1:0] drv;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (en_out[i]) begin
        drv[i] = en_pwm[i] ? lvl : 1'b1;
      end else begin
        drv[i] = 1'b0;
      end
    end
    return drv;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// -----------------------------------------------------------------------------
// pwm_timebase
// Prescaler plus 8-bit free-running PWM counter and period-boundary strobe.
// Runs continuously out of reset, independent of any pin enables.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   pwm_cnt  out  current PWM counter value (0..255)
//   wrap     out  combinational strobe: high in the cycle whose rising edge
//                 moves pwm_cnt from 255 to 0 (the period boundary edge)
// Parameter PRESCALE: system clocks per counter step, legal 1..65535.
// -----------------------------------------------------------------------------
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [PWM_CNT_W-1:0] pwm_cnt,
  output logic                 wrap
);

  localparam logic [PRE_CNT_W-1:0] PRE_LAST = PRE_CNT_W'(PRESCALE - 1);
  localparam logic [PWM_CNT_W-1:0] CNT_LAST = {PWM_CNT_W{1'b1}};

  logic [PRE_CNT_W-1:0] r_pre_cnt;
  logic [PWM_CNT_W-1:0] r_pwm_cnt;
  logic                 w_tick;

  // With PRESCALE = 1, PRE_LAST is 0 and the counter sits at 0, so tick is
  // high every cycle.
  assign w_tick  = (r_pre_cnt == PRE_LAST);
  assign wrap    = w_tick && (r_pwm_cnt == CNT_LAST);
  assign pwm_cnt = r_pwm_cnt;

  // Prescaler and PWM counter; the counter wraps 255 -> 0 by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt <= {PRE_CNT_W{1'b0}};
      r_pwm_cnt <= {PWM_CNT_W{1'b0}};
    end else begin
      if (w_tick) begin
        r_pre_cnt <= {PRE_CNT_W{1'b0}};
        r_pwm_cnt <= r_pwm_cnt + {{(PWM_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_pre_cnt <= r_pre_cnt + {{(PRE_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
// 16-pin output stage. Each pin is held low, driven high, or PWM-modulated
// from a single shared duty byte. The duty byte is shadowed and only taken
// over at a period boundary so a period in progress is never glitched.
// Ports:
//   clk              in   system clock
//   rst_n            in   asynchronous active-low reset
//   en_reg_out_7_0   in   output enable, pins 7:0
//   en_reg_out_15_8  in   output enable, pins 15:8
//   en_reg_pwm_7_0   in   PWM select, pins 7:0
//   en_reg_pwm_15_8  in   PWM select, pins 15:8
//   pwm_duty_cycle   in   requested duty in 1/256 units, 0xFF = 100 %
//   out              out  registered pin drive, bit i = pin i
//   period_start     out  one-clock pulse following each period boundary
// Parameter PRESCALE: system clocks per PWM step (period = 256*PRESCALE).
// -----------------------------------------------------------------------------
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           en_reg_out_7_0,
  input  logic [7:0]           en_reg_out_15_8,
  input  logic [7:0]           en_reg_pwm_7_0,
  input  logic [7:0]           en_reg_pwm_15_8,
  input  logic [7:0]           pwm_duty_cycle,
  output logic [NUM_PINS-1:0]  out,
  output logic                 period_start
);

  logic [PWM_CNT_W-1:0] w_pwm_cnt;
  logic                 w_wrap;
  logic [PWM_CNT_W-1:0] r_duty_act;
  logic [NUM_PINS-1:0]  r_out;
  logic                 r_period_start;
  logic [NUM_PINS-1:0]  w_en_out;
  logic [NUM_PINS-1:0]  w_en_pwm;
  logic                 w_lvl;
  logic [NUM_PINS-1:0]  w_out_nxt;
  logic [PWM_CNT_W-1:0] w_duty_nxt;

  pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk     (clk),
    .rst_n   (rst_n),
    .pwm_cnt (w_pwm_cnt),
    .wrap    (w_wrap)
  );

  assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Next-state logic: level compare, per-pin mux and duty shadow load.
  // Enables are used as-is so enable changes reach the pins after one clock.
  always_comb begin
    w_lvl      = 1'b0;
    w_out_nxt  = {NUM_PINS{1'b0}};
    w_duty_nxt = r_duty_act;
    w_lvl      = pwm_level(w_pwm_cnt, r_duty_act);
    w_out_nxt  = pin_drive(w_en_out, w_en_pwm, w_lvl);
    if (w_wrap) begin
      w_duty_nxt = pwm_duty_cycle;
    end else begin
      w_duty_nxt = r_duty_act;
    end
  end

  // Output, boundary-pulse and duty shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_act     <= {PWM_CNT_W{1'b0}};
      r_out          <= {NUM_PINS{1'b0}};
      r_period_start <= 1'b0;
    end else begin
      r_duty_act     <= w_duty_nxt;
      r_out          <= w_out_nxt;
      r_period_start <= w_wrap;
    end
  end

  assign out          = r_out;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_peripheral.sv
// -----------------------------------------------------------------------------
// tb_pwm_peripheral
// Randomized self-checking bench. The reference model tracks elapsed clocks
// since reset release and derives the PWM level from the position inside the
// period (pos < duty*PRESCALE, or duty full-scale), plus directed high-time
// measurements for the scenarios of interest.
// -----------------------------------------------------------------------------
module tb_pwm_peripheral;

  localparam int PRE    = 13;
  localparam int PERIOD = 256 * PRE;

  logic        clk;
  logic        rst_n;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  int n_checks;
  int n_errors;

  // model state
  int         m_t;      // rising edges since reset release
  int         m_duty;   // duty in force for the current period
  int         m_steps;  // edges since the most recent reset release

  pwm_peripheral #(
    .PRESCALE (PRE)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .period_start    (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    en_reg_out_7_0  = eo[7:0];
    en_reg_out_15_8 = eo[15:8];
    en_reg_pwm_7_0  = ep[7:0];
    en_reg_pwm_15_8 = ep[15:8];
    pwm_duty_cycle  = d;
  endtask

  // One clock: predict from the inputs present now, then compare at negedge.
  task automatic step();
    int          pos;
    logic        lvl;
    logic        bnd;
    logic [15:0] eo;
    logic [15:0] ep;
    logic [15:0] exp_out;
    pos = m_t % PERIOD;
    lvl = (m_duty == 255) || (pos < m_duty * PRE);
    bnd = ((m_t + 1) % PERIOD) == 0;
    eo  = {en_reg_out_15_8, en_reg_out_7_0};
    ep  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    for (int p = 0; p < 16; p++) begin
      exp_out[p] = eo[p] ? (ep[p] ? lvl : 1'b1) : 1'b0;
    end
    @(posedge clk);
    m_t++;
    m_steps++;
    if (bnd) m_duty = int'(pwm_duty_cycle);
    @(negedge clk);
    chk("out", 32'(out), 32'(exp_out));
    chk("period_start", 32'(period_start), 32'(bnd));
  endtask

  // Advance at least one clock until period_start is observed high.
  task automatic wait_ps();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < PERIOD + 10);
    if (!period_start) chk("ps_timeout", 32'(n), 32'(PERIOD));
  endtask

  // Count high clocks on pin b over one full period following period_start.
  task automatic measure(input int b, output int highs);
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step();
      if (out[b]) highs++;
    end
  endtask

  task automatic release_reset();
    rst_n   = 1'b1;
    m_t     = 0;
    m_duty  = 0;
    m_steps = 0;
  endtask

  initial begin
    int h;
    int h4;
    int h5;
    int first_ps;
    int last_ps;
    int bad;
    n_checks = 0;
    n_errors = 0;
    m_t = 0; m_duty = 0; m_steps = 0;

    // 1. reset with random inputs, then release with enables off
    rst_n = 1'b0;
    set_in(16'($urandom), 16'($urandom), 8'($urandom));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_out", 32'(out), 32'h0);
      chk("rst_ps", 32'(period_start), 32'h0);
      set_in(16'($urandom), 16'($urandom), 8'($urandom));
    end
    set_in(16'h0000, 16'($urandom), 8'($urandom));
    release_reset();
    first_ps = -1;
    last_ps  = 0;
    for (int i = 0; i < 10000; i++) begin
      if (i % 500 == 499) set_in(16'h0000, 16'($urandom), 8'($urandom));
      step();
      if (period_start) begin
        if (first_ps < 0) first_ps = m_steps;
        else chk("ps_interval", 32'(m_steps - last_ps), 32'(PERIOD));
        last_ps = m_steps;
      end
    end
    chk("first_ps", 32'(first_ps), 32'(PERIOD));

    // 2. static drive, then disabled pins with PWM selected
    set_in(16'hFFFF, 16'h0000, 8'h37);
    step();
    chk("static_on", 32'(out), 32'hFFFF);
    for (int i = 0; i < 20; i++) step();
    set_in(16'h0000, 16'hFFFF, 8'h37);
    step();
    chk("static_off", 32'(out), 32'h0000);
    for (int i = 0; i < 20; i++) step();

    // 3. 50 % duty with edge alignment against period_start
    set_in(16'h0001, 16'h0001, 8'h80);
    wait_ps();
    wait_ps();
    chk("half_ps_lvl", 32'(out[0]), 32'h0);
    step();
    chk("half_rise", 32'(out[0]), 32'h1);
    for (int i = 0; i < PERIOD - 1; i++) step();
    measure(0, h);
    chk("half_high", 32'(h), 32'd1664);

    // 4. extremes
    set_in(16'h0001, 16'h0001, 8'h00);
    wait_ps();
    h = 0;
    for (int k = 0; k < 3; k++) begin
      measure(0, h4);
      h += h4;
    end
    chk("duty00_high", 32'(h), 32'd0);
    set_in(16'h0001, 16'h0001, 8'hFF);
    wait_ps();
    h = 0;
    for (int k = 0; k < 3; k++) begin
      measure(0, h4);
      h += h4;
    end
    chk("dutyFF_high", 32'(h), 32'(3 * PERIOD));
    set_in(16'h0001, 16'h0001, 8'h01);
    wait_ps();
    measure(0, h);
    chk("duty01_high", 32'(h), 32'd13);

    // 5. mid-period update, then reset mid-period
    set_in(16'h0001, 16'h0001, 8'h40);
    wait_ps();
    h = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i == 1000) set_in(16'h0001, 16'h0001, 8'hC0);
      step();
      if (out[0]) h++;
    end
    chk("mid_old_high", 32'(h), 32'd832);
    measure(0, h);
    chk("mid_new_high", 32'(h), 32'd2496);
    for (int i = 0; i < 500; i++) step();
    chk("pre_rst_hi", 32'(out[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_out", 32'(out), 32'h0);
    chk("rst_async_ps", 32'(period_start), 32'h0);
    @(negedge clk);
    chk("rst_hold_out", 32'(out), 32'h0);
    release_reset();
    wait_ps();
    chk("rst_restart", 32'(m_steps), 32'(PERIOD));

    // 6. mixed pins
    set_in(16'h00F0, 16'h0030, 8'h40);
    wait_ps();
    h4 = 0; h5 = 0; bad = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step();
      if (out[4]) h4++;
      if (out[5]) h5++;
      if (out[7:6] != 2'b11 || out[4] != out[5] || out[15:8] != 8'h00 || out[3:0] != 4'h0) bad++;
    end
    chk("mixed_h4", 32'(h4), 32'd832);
    chk("mixed_h5", 32'(h5), 32'd832);
    chk("mixed_shape", 32'(bad), 32'd0);

    // 7. random enables and duty, checked cycle by cycle by the model
    for (int i = 0; i < 2 * PERIOD; i++) begin
      if (i % 64 == 0) set_in(16'($urandom), 16'($urandom), 8'($urandom));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
